// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller state enum and the step-counter width helper.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  // Step counter runs 0..width-1, so $clog2(width) bits suffice.
  function automatic int md_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate. Used for operand magnitudes before
// the iterative core and for sign correction of the finished result.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Pass through, or invert-and-increment when neg is set.
  always_comb begin
    y = neg ? (~x + W'(1)) : x;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair of the multi-cycle
// MIPS core. One result bit per cycle: shift-add for mult/multu, restoring
// shift-subtract for div/divu. Signed operations run on magnitudes and are
// sign-corrected in FIX.
// Optional build macro: MULDIV_FAST_MULT_EN -- mult/multu use a single-cycle
// multiplier in PREP and go straight to FIX; divide timing is unchanged.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt;

  // Operands latched at issue; data registers carry no reset.
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   acc_hi, acc_lo;

  logic               is_mult, signed_op, sign_diff, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign is_mult   = ~op_q[1];
  assign signed_op = ~op_q[0];
  assign sign_diff = signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign b_zero    = (b_q == '0);

  muldiv_negate #(.W(WIDTH)) u_abs_a (
    .neg (signed_op & a_q[WIDTH-1]),
    .x   (a_q),
    .y   (abs_a)
  );

  muldiv_negate #(.W(WIDTH)) u_abs_b (
    .neg (signed_op & b_q[WIDTH-1]),
    .x   (b_q),
    .y   (abs_b)
  );

  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg (sign_diff),
    .x   ({acc_hi, acc_lo}),
    .y   (prod_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_quot (
    .neg (sign_diff),
    .x   (acc_lo),
    .y   (quot_fix)
  );

  // Remainder follows the sign of the dividend.
  muldiv_negate #(.W(WIDTH)) u_fix_rem (
    .neg (signed_op & a_q[WIDTH-1]),
    .x   (acc_hi),
    .y   (rem_fix)
  );

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;

  // Single-cycle magnitude product used in PREP for mult/multu.
  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
  end
`endif

  // One iteration step: conditional add of the multiplicand, or trial subtract.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
  end

  // Controller state and step counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == PREP) cnt <= '0;
      else if (state == CALC) cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: begin
        state_nxt = CALC;
`ifdef MULDIV_FAST_MULT_EN
        if (is_mult) state_nxt = FIX;
`endif
      end
      CALC: if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    div_by_zero = (state == DONE) && !is_mult && b_zero;
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
        end
      end
      PREP: begin
        mag_b <= abs_b;
`ifdef MULDIV_FAST_MULT_EN
        if (is_mult) begin
          {acc_hi, acc_lo} <= fast_prod;
        end else begin
          acc_hi <= '0;
          acc_lo <= abs_a;
        end
`else
        acc_hi <= '0;
        acc_lo <= abs_a;
`endif
      end
      CALC: begin
        if (is_mult) begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // HI/LO: mthi/mtlo in IDLE, sign-corrected result in FIX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end else if (state == FIX) begin
      if (is_mult) begin
        {hi, lo} <= prod_fix;
      end else if (b_zero) begin
        hi <= a_q;
        lo <= '1;
      end else begin
        hi <= rem_fix;
        lo <= quot_fix;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          wr_hi, wr_lo;
  logic [W-1:0]  wr_data;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the architectural result from plain 64-bit arithmetic.
  task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edbz);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    edbz = 1'b0;
    case (mop)
      2'b00: begin sq = sa * sb; eh = sq[63:32]; el = sq[31:0]; end
      2'b01: begin p = {32'd0, ma} * {32'd0, mb}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (mb == 0) begin
          eh = ma; el = '1; edbz = 1'b1;
        end else if (mop == 2'b10) begin
          sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0];
        end else begin
          eh = ma % mb; el = ma / mb;
        end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] mop);
`ifdef MULDIV_FAST_MULT_EN
    if (mop[1] == 1'b0) return 2;
`endif
    return W + 2;
  endfunction

  // Drive start for one edge (E0); returns #1 after E0 with the edge count.
  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output int t0);
    start = 1'b1; op = iop; a = ia; b = ib;
    tick();
    start = 1'b0;
    t0 = cyc;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Wait (bounded) for done, then check latency, result and the return to IDLE.
  task automatic wait_done(input string tag, input int t0, input int lat,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input logic edbz);
    int guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_latency"}, cyc - t0, lat);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dbz"}, div_by_zero, edbz);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] rop, input logic [W-1:0] ra,
                        input logic [W-1:0] rb);
    logic [W-1:0] eh, el;
    logic edbz;
    int t0;
    model(rop, ra, rb, eh, el, edbz);
    issue(rop, ra, rb, t0);
    wait_done(tag, t0, exp_lat(rop), eh, el, edbz);
  endtask

  initial begin
    logic [W-1:0] eh, el, hi_before;
    logic edbz;
    int t0;

    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    tick();
    tick();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b1;
    tick();

    // Directed cases with hand-derived expectations.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
    wait_done("multu_max", t0, exp_lat(2'b01), 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, t0);
    wait_done("mult_neg", t0, exp_lat(2'b00), 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, t0);
    wait_done("div_neg", t0, W + 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, t0);
    wait_done("div_min", t0, W + 2, 32'h0, 32'h8000_0000, 1'b0);
    issue(2'b11, 32'd100, 32'd0, t0);
    wait_done("divu_zero", t0, W + 2, 32'h64, 32'hFFFF_FFFF, 1'b1);

    // Start and mthi while busy are ignored.
    issue(2'b11, 32'd10, 32'd3, t0);
    repeat (5) tick();
    hi_before = hi;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd7;
    wr_hi = 1'b1; wr_data = 32'h1234;
    tick();
    start = 1'b0; wr_hi = 1'b0;
    check("mthi_busy_ignored", hi, hi_before);
    wait_done("divu_10_3", t0, W + 2, 32'd1, 32'd3, 1'b0);

    // mtlo in IDLE.
    wr_lo = 1'b1; wr_data = 32'hABCD;
    tick();
    wr_lo = 1'b0;
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_hi_kept", hi, 32'd1);

    // Write coinciding with start: the result overwrites it.
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5555_5555;
    issue(2'b01, 32'd4, 32'd5, t0);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthilo_with_start", {hi, lo}, {32'h5555_5555, 32'h5555_5555});
    wait_done("multu_4_5", t0, exp_lat(2'b01), 32'd0, 32'd20, 1'b0);

    // Reset during the 10th CALC cycle discards the operation.
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, t0);
    repeat (10) tick();
    rst = 1'b0;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    rst = 1'b1;
    tick();
    issue(2'b01, 32'd2, 32'd3, t0);
    wait_done("multu_2_3", t0, exp_lat(2'b01), 32'd0, 32'd6, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = -32'($urandom_range(1, 100));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, eh, el, edbz);
      issue(rop, ra, rb, t0);
      wait_done($sformatf("rand%0d_op%0d", i, rop), t0, exp_lat(rop), eh, el, edbz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
